uart_byte_tx: RTL

UART transmitter that serialises bytes onto the board-side TXD line driven into the soft core's UART receive pin (GPIO_0[0]). Bytes arrive on a ready/valid port, are buffered in a small FIFO, and are sent LSB-first as 8N1 frames at a fixed baud rate derived from the system clock. The block runs on the same clock as the processor system (CLOCK_50 or the manual debug clock) and feeds host-side or loopback traffic into the core.

---
 rtl/uart_byte_tx.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_byte_tx.sv
// uart_byte_tx -- byte-wide UART transmitter with a small input FIFO.
//
// Bytes are accepted on a ready/valid port, queued in a FIFO_DEPTH-entry
// FIFO and sent LSB-first as 8N1 frames. Each bit lasts
// CLKS_PER_BIT = CLK_FREQ_HZ / BAUD cycles. When the FIFO still holds data
// at the end of a stop bit, the next start bit follows immediately.
//
// Optional feature: define UART_BYTE_TX_PARITY_EN to insert an even parity
// bit between data bit 7 and the stop bit, which gives 11-bit frames.
//
// Parameters:
//   CLK_FREQ_HZ  system clock frequency in Hz
//   BAUD         line rate; CLK_FREQ_HZ / BAUD must be >= 2
//   FIFO_DEPTH   FIFO entries; power of two, >= 2
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high; flushes the FIFO, aborts any frame
//   tx_data     byte to queue
//   tx_valid    tx_data valid; push happens when tx_valid && tx_ready
//   tx_ready    FIFO not full (combinational from the FIFO count only)
//   txd         serial line, idle high, registered
//   busy        frame on the line, registered
//   fifo_count  occupied FIFO entries
module uart_byte_tx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = CLK_FREQ_HZ / BAUD;
  localparam int BCW = $clog2(CPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

`ifdef UART_BYTE_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [BCW-1:0]   baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       mem [FIFO_DEPTH];
`ifdef UART_BYTE_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             push;
  logic             pop;
  logic             baud_end;
  logic             not_empty;
  logic [7:0]       head;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign not_empty  = (count_q != '0);
  assign baud_end   = (baud_q == BCW'(CPB - 1));
  assign head       = mem[rptr_q];

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

  // FIFO bookkeeping
  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: next state, pop request and registered-output values
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_BYTE_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_BYTE_TX_PARITY_EN
          par_d   = ^head;
`endif
          bit_d   = 3'd0;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d  = baud_q + BCW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_BYTE_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
`ifdef UART_BYTE_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d  = baud_q + BCW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (not_empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_BYTE_TX_PARITY_EN
            par_d   = ^head;
`endif
            bit_d   = 3'd0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered from the next state so the line changes on the
    // same edge as the state register.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_BYTE_TX_PARITY_EN
      PARITY:  txd_d = par_d;
`endif
      default: txd_d = 1'b1;
    endcase

    // Rises with the start bit, falls the cycle after the last stop cycle.
    busy_d = (state_d != IDLE) || (count_q != '0);
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Data registers: FIFO storage and shift register need no reset
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef UART_BYTE_TX_PARITY_EN
    par_q   <= par_d;
`endif
    if (push) begin
      mem[wptr_q] <= tx_data;
    end
  end

endmodule
